// File: rtl/ktms_mmrd_resp.sv
// MMIO read responder for one context-addressed register window.
// Optional response timeout is enabled by defining KTMS_MMRD_TIMEOUT_EN.
module ktms_mmrd_resp #(
    parameter int unsigned           addr_width    = 24,
    parameter int unsigned           mmiobus_width = 4 + addr_width + 64,
    parameter int unsigned           lcladdr_width = 1,
    parameter logic [addr_width-1:0] addr          = '0,
    parameter int unsigned           tmo_width     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [mmiobus_width-1:0] i_mmiobus,
    output logic                     o_rd_v,
    input  logic                     o_rd_r,
    output logic [lcladdr_width-1:0] o_rd_addr,
    input  logic                     i_rd_v,
    input  logic [0:63]              i_rd_d,
    output logic                     o_ack,
    output logic [0:63]              o_data,
    output logic                     o_tmo,
    output logic                     o_ovr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state;

    logic                  bus_vld;
    logic                  bus_cfg;
    logic                  bus_rnw;
    logic                  bus_dw;
    logic [addr_width-1:0] req_addr;
    logic                  match;
    logic                  start;
    logic                  dw_q;
    logic                  ws_q;
    logic [0:63]           rd_fmt;

    assign bus_vld  = i_mmiobus[mmiobus_width-1];
    assign bus_cfg  = i_mmiobus[mmiobus_width-2];
    assign bus_rnw  = i_mmiobus[mmiobus_width-3];
    assign bus_dw   = i_mmiobus[mmiobus_width-4];
    assign req_addr = i_mmiobus[mmiobus_width-5 -: addr_width];

    // Match is done on the dword address addr[addr_width-1:1]; its low
    // lcladdr_width bits select the local register and are not compared.
    localparam logic [addr_width-2:0] dmask = {(addr_width-1){1'b1}} << lcladdr_width;

    assign match = ((req_addr[addr_width-1:1] ^ addr[addr_width-1:1]) & dmask) == '0;
    assign start = bus_vld & ~bus_cfg & bus_rnw & match;

    always_comb begin
        rd_fmt = i_rd_d;
        if (!dw_q) begin
            if (ws_q) rd_fmt = {i_rd_d[0:31], i_rd_d[0:31]};
            else      rd_fmt = {i_rd_d[32:63], i_rd_d[32:63]};
        end
    end

`ifdef KTMS_MMRD_TIMEOUT_EN
    logic [tmo_width-1:0] tmo_cnt;
    logic [tmo_width-1:0] tmo_nxt;
    logic                 tmo_hit;

    // Fires on the cycle the counter would become all-ones, so the forced
    // ack lands 2^tmo_width-1 cycles after the request transfer.
    assign tmo_nxt = tmo_cnt + tmo_width'(1);
    assign tmo_hit = &tmo_nxt;
`else
    assign o_tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            o_rd_v    <= 1'b0;
            o_rd_addr <= '0;
            o_ack     <= 1'b0;
            o_data    <= '0;
            o_ovr     <= 1'b0;
            dw_q      <= 1'b0;
            ws_q      <= 1'b0;
`ifdef KTMS_MMRD_TIMEOUT_EN
            o_tmo     <= 1'b0;
            tmo_cnt   <= '0;
`endif
        end else begin
            if (start && state != S_IDLE) o_ovr <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_REQ;
                        o_rd_v    <= 1'b1;
                        o_rd_addr <= req_addr[lcladdr_width:1];
                        dw_q      <= bus_dw;
                        ws_q      <= ~bus_dw & req_addr[0];
                    end
                end
                S_REQ: begin
                    if (o_rd_r) begin
                        state  <= S_WAIT;
                        o_rd_v <= 1'b0;
`ifdef KTMS_MMRD_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (i_rd_v) begin
                        state  <= S_RESP;
                        o_ack  <= 1'b1;
                        o_data <= rd_fmt;
                    end
`ifdef KTMS_MMRD_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state  <= S_RESP;
                        o_ack  <= 1'b1;
                        o_tmo  <= 1'b1;
                        o_data <= '1;
                    end else begin
                        tmo_cnt <= tmo_nxt;
                    end
`endif
                end
                S_RESP: begin
                    state <= S_IDLE;
                    o_ack <= 1'b0;
`ifdef KTMS_MMRD_TIMEOUT_EN
                    o_tmo <= 1'b0;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{i_mmiobus[mmiobus_width-5-addr_width:0], (tmo_width > 0)};

endmodule

// File: tb/tb_ktms_mmrd_resp.sv
// Scoreboard bench for ktms_mmrd_resp; timeout cases run when KTMS_MMRD_TIMEOUT_EN is defined.
module tb_ktms_mmrd_resp;

    localparam logic [23:0] BASE = 24'h000010;

    logic        clk = 1'b0;
    logic        reset;
    logic [91:0] mmiobus;
    logic        o_rd_v;
    logic        o_rd_r;
    logic [0:0]  o_rd_addr;
    logic        i_rd_v;
    logic [0:63] i_rd_d;
    logic        o_ack;
    logic [0:63] o_data;
    logic        o_tmo;
    logic        o_ovr;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;

    typedef struct {
        logic [63:0] d;
        bit          tmo;
        int unsigned cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    ktms_mmrd_resp #(
        .addr_width    (24),
        .mmiobus_width (92),
        .lcladdr_width (1),
        .addr          (BASE),
        .tmo_width     (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_mmiobus (mmiobus),
        .o_rd_v    (o_rd_v),
        .o_rd_r    (o_rd_r),
        .o_rd_addr (o_rd_addr),
        .i_rd_v    (i_rd_v),
        .i_rd_d    (i_rd_d),
        .o_ack     (o_ack),
        .o_data    (o_data),
        .o_tmo     (o_tmo),
        .o_ovr     (o_ovr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    function automatic logic [91:0] mk(input bit v, input bit c, input bit r, input bit w,
                                       input logic [23:0] a);
        return {v, c, r, w, a, 64'hA5A5_5A5A_0F0F_F0F0};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every ack must match the oldest expected response.
    always @(negedge clk) begin
        if (o_ack) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack data %h tmo %0b, required no ack", o_data, o_tmo);
            end else begin
                mon_e = sb.pop_front();
                chk("ack_data", o_data, mon_e.d);
                chk("ack_tmo", {63'd0, o_tmo}, {63'd0, mon_e.tmo});
                chk("ack_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end else if (o_tmo) begin
            checks++;
            errors++;
            $display("FAIL tmo_without_ack: got o_tmo 1, required 0");
        end
    end

    task automatic rd_txn(input logic [23:0] a, input bit dw, input logic [63:0] d,
                          input logic [63:0] exp_d, input logic exp_la,
                          input int unsigned stall, input bit ovl);
        exp_t e;
        tick;
        mmiobus = mk(1'b1, 1'b0, 1'b1, dw, a);
        o_rd_r  = (stall == 0);
        e.d   = exp_d;
        e.tmo = 1'b0;
        e.cyc = cyc + 3 + stall;
        sb.push_back(e);
        tick;
        mmiobus = mk(1'b0, 1'b0, 1'b1, dw, a);
        chk("rd_v_rise", {63'd0, o_rd_v}, 64'd1);
        chk("rd_addr", {63'd0, o_rd_addr}, {63'd0, exp_la});
        for (int unsigned i = 0; i < stall; i++) begin
            tick;
            mmiobus = mk(ovl && i == 0, 1'b0, 1'b1, dw, a);
            chk("rd_v_hold", {63'd0, o_rd_v}, 64'd1);
            chk("rd_addr_hold", {63'd0, o_rd_addr}, {63'd0, exp_la});
            if (i == stall - 1) o_rd_r = 1'b1;
        end
        tick;
        chk("rd_v_fall", {63'd0, o_rd_v}, 64'd0);
        o_rd_r = 1'b0;
        i_rd_v = 1'b1;
        i_rd_d = d;
        tick;
        i_rd_v = 1'b0;
        i_rd_d = 64'hDEAD_BEEF_DEAD_BEEF;
        tick;
        tick;
    endtask

    task automatic no_txn(input string nm, input bit c, input bit r, input logic [23:0] a);
        tick;
        mmiobus = mk(1'b1, c, r, 1'b1, a);
        tick;
        mmiobus = mk(1'b0, c, r, 1'b1, a);
        repeat (4) begin
            tick;
            chk(nm, {63'd0, o_rd_v}, 64'd0);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_rd_v"}, {63'd0, o_rd_v}, 64'd0);
        chk({nm, "_ack"}, {63'd0, o_ack}, 64'd0);
        chk({nm, "_tmo"}, {63'd0, o_tmo}, 64'd0);
        chk({nm, "_ovr"}, {63'd0, o_ovr}, 64'd0);
        chk({nm, "_data"}, o_data, 64'd0);
        chk({nm, "_rd_addr"}, {63'd0, o_rd_addr}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        reset   = 1'b0;
        mmiobus = '0;
        o_rd_r  = 1'b0;
        i_rd_v  = 1'b0;
        i_rd_d  = '0;
        repeat (3) tick;
        chk_zero("reset");
        reset = 1'b1;
        tick;

        rd_txn(BASE,          1'b1, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0, 0, 1'b0);
        rd_txn(BASE,          1'b0, 64'hAAAA_BBBB_CCCC_DDDD, 64'hCCCC_DDDD_CCCC_DDDD, 1'b0, 0, 1'b0);
        rd_txn(BASE + 24'd1,  1'b0, 64'hAAAA_BBBB_CCCC_DDDD, 64'hAAAA_BBBB_AAAA_BBBB, 1'b0, 0, 1'b0);
        rd_txn(BASE + 24'd1,  1'b1, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788, 1'b0, 0, 1'b0);
        rd_txn(BASE + 24'd2,  1'b0, 64'hAAAA_BBBB_CCCC_DDDD, 64'hCCCC_DDDD_CCCC_DDDD, 1'b1, 0, 1'b0);
        rd_txn(BASE + 24'd3,  1'b0, 64'h0F0E_0D0C_0B0A_0908, 64'h0F0E_0D0C_0F0E_0D0C, 1'b1, 0, 1'b0);

        no_txn("filt_cfg",   1'b1, 1'b1, BASE);
        no_txn("filt_write", 1'b0, 1'b0, BASE);
        no_txn("filt_adr4",  1'b0, 1'b1, BASE + 24'd4);
        no_txn("filt_upper", 1'b0, 1'b1, BASE | 24'h100000);
        chk("ovr_clear", {63'd0, o_ovr}, 64'd0);

        rd_txn(BASE + 24'd3,  1'b1, 64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210, 1'b1, 5, 1'b0);
        chk("ovr_after_stall", {63'd0, o_ovr}, 64'd0);
        rd_txn(BASE,          1'b0, 64'h1234_5678_9ABC_DEF0, 64'h9ABC_DEF0_9ABC_DEF0, 1'b0, 3, 1'b1);
        chk("ovr_set", {63'd0, o_ovr}, 64'd1);

`ifdef KTMS_MMRD_TIMEOUT_EN
        // Timeout: ack forced 15 cycles after the transfer, late data ignored.
        tick;
        mmiobus = mk(1'b1, 1'b0, 1'b1, 1'b1, BASE);
        o_rd_r  = 1'b1;
        e.d = '1; e.tmo = 1'b1; e.cyc = cyc + 17;
        sb.push_back(e);
        tick;
        mmiobus = mk(1'b0, 1'b0, 1'b1, 1'b1, BASE);
        tick;
        o_rd_r = 1'b0;
        repeat (16) tick;
        i_rd_v = 1'b1;
        i_rd_d = 64'h5555_6666_7777_8888;
        tick;
        i_rd_v = 1'b0;
        repeat (4) tick;

        // Data arriving on the terminal-count cycle wins over the timeout.
        tick;
        mmiobus = mk(1'b1, 1'b0, 1'b1, 1'b1, BASE);
        o_rd_r  = 1'b1;
        e.d = 64'h0BAD_CAFE_1234_5678; e.tmo = 1'b0; e.cyc = cyc + 17;
        sb.push_back(e);
        tick;
        mmiobus = mk(1'b0, 1'b0, 1'b1, 1'b1, BASE);
        tick;
        o_rd_r = 1'b0;
        repeat (14) tick;
        i_rd_v = 1'b1;
        i_rd_d = 64'h0BAD_CAFE_1234_5678;
        tick;
        i_rd_v = 1'b0;
        repeat (4) tick;
`endif

        // Reset while waiting for read data: transaction abandoned.
        tick;
        mmiobus = mk(1'b1, 1'b0, 1'b1, 1'b0, BASE + 24'd2);
        o_rd_r  = 1'b1;
        tick;
        mmiobus = mk(1'b0, 1'b0, 1'b1, 1'b0, BASE + 24'd2);
        tick;
        o_rd_r = 1'b0;
        tick;
        reset = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        chk_zero("rst_wait");
        tick;
        i_rd_v = 1'b1;
        i_rd_d = 64'h7777_8888_9999_AAAA;
        tick;
        i_rd_v = 1'b0;
        repeat (4) tick;
        chk_zero("post_rst");

        rd_txn(BASE + 24'd2,  1'b1, 64'hC0FF_EE00_1111_2222, 64'hC0FF_EE00_1111_2222, 1'b1, 1, 1'b0);

        repeat (5) tick;
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
